// File: rtl/draw_sprite.sv
// Sprite overlay stage for a VGA pixel stream: frame-latched position, colour-key transparency, 2-cycle latency.
// rom_addr serves as the external ROM's address register; rom_data for that address is consumed in the next cycle.
module draw_sprite #(
    parameter int          SPRITE_W  = 32,
    parameter int          SPRITE_H  = 32,
    parameter int          ADDR_W    = 10,
    parameter logic [11:0] KEY_COLOR = 12'h000
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [10:0]       hcount_in,
    input  logic [10:0]       vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    input  logic              enable,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [10:0]       hcount_out,
    output logic [10:0]       vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out
);
    localparam int XW = $clog2(SPRITE_W);
    localparam int TW = 26;

    logic        vblnk_prev_reg;
    logic [10:0] xpos_l_reg;
    logic [10:0] ypos_l_reg;
    logic        en_l_reg;

    // Position and enable only change at the start of vertical blank, so a frame never tears.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vblnk_prev_reg <= 1'b0;
            xpos_l_reg     <= '0;
            ypos_l_reg     <= '0;
            en_l_reg       <= 1'b0;
        end else begin
            vblnk_prev_reg <= vblnk_in;
            if (vblnk_in && !vblnk_prev_reg) begin
                xpos_l_reg <= xpos;
                ypos_l_reg <= ypos;
                en_l_reg   <= enable;
            end
        end
    end

    logic [11:0]    rel_x;
    logic [11:0]    rel_y;
    logic           x_hit;
    logic           y_hit;
    logic           in_box;
    logic [11+XW:0] addr_full;

    // Signed 12-bit offsets: a negative offset (sign bit set) is left of / above the sprite.
    assign rel_x     = {1'b0, hcount_in} - {1'b0, xpos_l_reg};
    assign rel_y     = {1'b0, vcount_in} - {1'b0, ypos_l_reg};
    assign x_hit     = !rel_x[11] && (rel_x < 12'(SPRITE_W));
    assign y_hit     = !rel_y[11] && (rel_y < 12'(SPRITE_H));
    assign in_box    = en_l_reg && !hblnk_in && !vblnk_in && x_hit && y_hit;
    assign addr_full = {rel_y, rel_x[XW-1:0]};

    logic [TW-1:0] timing_in;
    logic [TW-1:0] timing_reg [0:1];

    assign timing_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_delay
            always_ff @(posedge pclk or posedge rst) begin
                if (rst) begin
                    timing_reg[gi] <= '0;
                end else begin
                    timing_reg[gi] <= (gi == 0) ? timing_in : timing_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    logic        in_box_reg;
    logic [11:0] rgb_reg;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            in_box_reg <= 1'b0;
            rgb_reg    <= '0;
            rom_addr   <= '0;
        end else begin
            in_box_reg <= in_box;
            rgb_reg    <= rgb_in;
            rom_addr   <= in_box ? addr_full[ADDR_W-1:0] : '0;
        end
    end

    logic        blank_s1;
    logic [11:0] rgb_next;

    assign blank_s1 = timing_reg[0][1] | timing_reg[0][0];

    // rom_data is only looked at inside the box, so undefined ROM words never reach the output.
    always_comb begin
        rgb_next = rgb_reg;
        if (blank_s1) begin
            rgb_next = 12'h000;
        end else if (in_box_reg && (rom_data != KEY_COLOR)) begin
            rgb_next = rom_data;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= rgb_next;
        end
    end

    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = timing_reg[1];

endmodule
